// File: rtl/uptx_pkg.sv
// uptx_pkg: shared definitions for the USB-PD style transmit framer.
// Holds the FSM state encoding, K-code symbols, 4b5b table, CRC32
// constants, ordered-set lookup and per-state terminal bit counts.
package uptx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREA = 3'd1,
    ST_SOPS = 3'd2,
    ST_DATA = 3'd3,
    ST_CRC  = 3'd4,
    ST_EOP  = 3'd5,
    ST_TAIL = 3'd6
  } state_t;

  // K-codes, transmitted LSB first
  localparam logic [4:0] K_S1  = 5'b11000;
  localparam logic [4:0] K_S2  = 5'b10001;
  localparam logic [4:0] K_S3  = 5'b00110;
  localparam logic [4:0] K_R1  = 5'b00111;
  localparam logic [4:0] K_R2  = 5'b11001;
  localparam logic [4:0] K_EOP = 5'b01101;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  function automatic logic [4:0] enc4b5b(input logic [3:0] nib);
    case (nib)
      4'h0: enc4b5b = 5'b11110;
      4'h1: enc4b5b = 5'b01001;
      4'h2: enc4b5b = 5'b10100;
      4'h3: enc4b5b = 5'b10101;
      4'h4: enc4b5b = 5'b01010;
      4'h5: enc4b5b = 5'b01011;
      4'h6: enc4b5b = 5'b01110;
      4'h7: enc4b5b = 5'b01111;
      4'h8: enc4b5b = 5'b10010;
      4'h9: enc4b5b = 5'b10011;
      4'hA: enc4b5b = 5'b10110;
      4'hB: enc4b5b = 5'b10111;
      4'hC: enc4b5b = 5'b11010;
      4'hD: enc4b5b = 5'b11011;
      4'hE: enc4b5b = 5'b11100;
      default: enc4b5b = 5'b11101;
    endcase
  endfunction

  // Four K-codes packed so the first one sent sits in bits [4:0]
  function automatic logic [19:0] ords_set(input logic [2:0] ords);
    case (ords)
      3'd1: ords_set = {K_S2, K_S1, K_S1, K_S1};
      3'd2: ords_set = {K_S3, K_S3, K_S1, K_S1};
      3'd3: ords_set = {K_S3, K_S1, K_S3, K_S1};
      3'd4: ords_set = {K_S3, K_R2, K_R2, K_S1};
      3'd5: ords_set = {K_S2, K_S3, K_R2, K_S1};
      3'd6: ords_set = {K_R2, K_R1, K_R1, K_R1};
      3'd7: ords_set = {K_S3, K_R1, K_S1, K_R1};
      default: ords_set = '0;
    endcase
  endfunction

  // Index of the last bit of each segment
  function automatic logic [6:0] last_cnt(input state_t st);
    case (st)
      ST_PREA: last_cnt = 7'd63;
      ST_SOPS: last_cnt = 7'd19;
      ST_DATA: last_cnt = 7'd9;
      ST_CRC:  last_cnt = 7'd39;
      ST_EOP:  last_cnt = 7'd4;
      default: last_cnt = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/uptx_crc32.sv
// uptx_crc32: bit-serial CRC32 (poly 0x04C11DB7), data fed LSB first.
// Ports: clk/arst; init_i reloads 0xFFFFFFFF; bit_vld_i/bit_i shift one
// payload bit; crc_o is the raw register (caller reflects/inverts it).
module uptx_crc32 import uptx_pkg::*; (
  input  logic        clk,
  input  logic        arst,
  input  logic        init_i,
  input  logic        bit_vld_i,
  input  logic        bit_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[31] ^ bit_i;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (bit_vld_i) begin
      crc_d = {crc_q[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) crc_q <= CRC_INIT;
    else      crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/uptx_framer.sv
// uptx_framer: serialises preamble, ordered set, 4b5b payload, CRC32, EOP.
// Inputs: clk, arst, ptx_hui half-UI tick, prl_txreq/prl_txauto request,
// prl_rdat/prl_last payload. Outputs: ptx_fifopop, ptx_txact, ptx_ack,
// ptx_line, ptx_oe. Define UPTX_BMC_EN for BMC line coding (else NRZ).
module uptx_framer import uptx_pkg::*; (
  input  logic       clk,
  input  logic       arst,
  input  logic       ptx_hui,
  input  logic       prl_txreq,
  input  logic [6:0] prl_txauto,
  input  logic [7:0] prl_rdat,
  input  logic       prl_last,
  output logic       ptx_fifopop,
  output logic       ptx_txact,
  output logic       ptx_ack,
  output logic       ptx_line,
  output logic       ptx_oe
);

  state_t      state_q, state_d, tgt, seg_next;
  logic [6:0]  cnt_q, cnt_d;
  logic [4:0]  ctl_q, ctl_d;
  logic [7:0]  byte_q, byte_d;
  logic [39:0] shf_q, shf_d, crc_sym;
  logic [31:0] crc_val, crc_tx;
  logic        run_q, run_d, txact_q, txact_d, ack_q, ack_d, last_q, last_d;
  logic        ph_q, bnd, mid, enter, pop, crc_init, crc_vld, cur_bit;
  logic        rsvd_unused;

  assign rsvd_unused = prl_txauto[6];

  // ph_q=0 means the next tick is a bit boundary, so the first tick
  // after reset starts a bit
  assign bnd = ptx_hui & ~ph_q;
  assign mid = ptx_hui &  ph_q;

  // Transmitted CRC: bit-reversed one's complement, 4b5b per nibble
  always_comb begin
    crc_tx  = '0;
    crc_sym = '0;
    for (int i = 0; i < 32; i++) crc_tx[i] = ~crc_val[31-i];
    for (int i = 0; i < 8; i++) crc_sym[i*5 +: 5] = enc4b5b(crc_tx[i*4 +: 4]);
  end

  // Segment that follows the current one once its last bit is done
  always_comb begin
    seg_next = ST_IDLE;
    case (state_q)
      ST_PREA: seg_next = (ctl_q[2:0] == 3'd0) ? ST_DATA : ST_SOPS;
      ST_SOPS: seg_next = (ctl_q[2:0] >= 3'd6) ? ST_TAIL : ST_DATA;
      ST_DATA: seg_next = !last_q  ? ST_DATA :
                          ctl_q[4] ? ST_CRC  :
                          ctl_q[3] ? ST_EOP  : ST_TAIL;
      ST_CRC:  seg_next = ctl_q[3] ? ST_EOP : ST_TAIL;
      ST_EOP:  seg_next = ST_TAIL;
      default: seg_next = ST_IDLE;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctl_d    = ctl_q;
    byte_d   = byte_q;
    shf_d    = shf_q;
    run_d    = run_q;
    txact_d  = txact_q;
    ack_d    = 1'b0;
    last_d   = last_q;
    tgt      = seg_next;
    enter    = 1'b0;
    pop      = 1'b0;
    crc_init = 1'b0;
    if (state_q == ST_IDLE) begin
      if (prl_txreq) begin
        ctl_d    = prl_txauto[4:0];
        txact_d  = 1'b1;
        cnt_d    = '0;
        last_d   = 1'b0;
        crc_init = 1'b1;
        state_d  = prl_txauto[5] ? ST_PREA :
                   (prl_txauto[2:0] != 3'd0) ? ST_SOPS : ST_DATA;
      end
    end else if (bnd) begin
      // run_q=0: frame accepted but its first bit not yet started
      if (!run_q) begin
        tgt   = state_q;
        enter = 1'b1;
        run_d = 1'b1;
      end else if (cnt_q == last_cnt(state_q)) begin
        enter = 1'b1;
      end else begin
        cnt_d = cnt_q + 7'd1;
        shf_d = {1'b0, shf_q[39:1]};
      end
      if (enter) begin
        state_d = tgt;
        cnt_d   = '0;
        case (tgt)
          ST_SOPS: shf_d = {20'd0, ords_set(ctl_q[2:0])};
          ST_DATA: begin
            pop    = 1'b1;
            byte_d = prl_rdat;
            last_d = prl_last;
            shf_d  = {30'd0, enc4b5b(prl_rdat[7:4]), enc4b5b(prl_rdat[3:0])};
          end
          ST_CRC:  shf_d = crc_sym;
          ST_EOP:  shf_d = {35'd0, K_EOP};
          ST_IDLE: begin
            run_d   = 1'b0;
            txact_d = 1'b0;
            ack_d   = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Raw payload bits go into the CRC as they finish on the line
  assign crc_vld = bnd & run_q & (state_q == ST_DATA) & (cnt_q < 7'd8);
  assign cur_bit = (state_q == ST_PREA) ? cnt_q[0] : shf_q[0];

  uptx_crc32 u_crc (
    .clk       (clk),
    .arst      (arst),
    .init_i    (crc_init),
    .bit_vld_i (crc_vld),
    .bit_i     (byte_q[cnt_q[2:0]]),
    .crc_o     (crc_val)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctl_q   <= '0;
      byte_q  <= '0;
      shf_q   <= '0;
      run_q   <= 1'b0;
      txact_q <= 1'b0;
      ack_q   <= 1'b0;
      last_q  <= 1'b0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      byte_q  <= byte_d;
      shf_q   <= shf_d;
      run_q   <= run_d;
      txact_q <= txact_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      if (ptx_hui) ph_q <= ~ph_q;
    end
  end

`ifdef UPTX_BMC_EN
  logic lvl_q, lvl_d;

  always_comb begin
    lvl_d = lvl_q;
    if (state_q == ST_IDLE || !run_q) begin
      lvl_d = 1'b0;
    end else if (bnd) begin
      // TAIL keeps the final level for its first half-UI
      if (state_d == ST_IDLE)     lvl_d = 1'b0;
      else if (state_d != ST_TAIL) lvl_d = ~lvl_q;
    end else if (mid) begin
      lvl_d = (state_q == ST_TAIL) ? 1'b0 : (lvl_q ^ cur_bit);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) lvl_q <= 1'b0;
    else      lvl_q <= lvl_d;
  end

  assign ptx_line = run_q & lvl_q;
`else
  assign ptx_line = run_q & (state_q != ST_TAIL) & cur_bit;
`endif

  assign ptx_fifopop = pop;
  assign ptx_txact   = txact_q;
  assign ptx_ack     = ack_q;
  assign ptx_oe      = run_q;

endmodule

// File: tb/tb_uptx_framer.sv
module tb_uptx_framer;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       ptx_hui = 1'b0;
  logic       prl_txreq = 1'b0;
  logic [6:0] prl_txauto = '0;
  logic [7:0] prl_rdat = '0;
  logic       prl_last = 1'b0;
  logic       ptx_fifopop, ptx_txact, ptx_ack, ptx_line, ptx_oe;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111, R2 = 5'b11001, EOPK = 5'b01101;
  logic [4:0] enc_t [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                             5'b01010, 5'b01011, 5'b01110, 5'b01111,
                             5'b10010, 5'b10011, 5'b10110, 5'b10111,
                             5'b11010, 5'b11011, 5'b11100, 5'b11101};

  logic [7:0] pay[$];
  bit         expq[$];
  logic       smp[$];
  int         idx = 0, pops = 0, acks = 0;
  bit         pend = 0, prev_oe = 0;

  uptx_framer dut (
    .clk         (clk),
    .arst        (arst),
    .ptx_hui     (ptx_hui),
    .prl_txreq   (prl_txreq),
    .prl_txauto  (prl_txauto),
    .prl_rdat    (prl_rdat),
    .prl_last    (prl_last),
    .ptx_fifopop (ptx_fifopop),
    .ptx_txact   (ptx_txact),
    .ptx_ack     (ptx_ack),
    .ptx_line    (ptx_line),
    .ptx_oe      (ptx_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // half-UI tick: one clock high out of every four
  initial begin
    int h = 0;
    forever begin
      @(posedge clk); #1;
      ptx_hui = (h == 3);
      h = (h + 1) % 4;
    end
  end

  // payload source: advance one entry after each pop has been captured
  initial forever begin
    @(negedge clk);
    if (pend) begin idx++; pend = 0; end
    if (ptx_fifopop === 1'b1) begin pops++; pend = 1; end
    if (idx < pay.size()) begin
      prl_rdat = pay[idx];
      prl_last = (idx == pay.size() - 1);
    end else begin
      prl_rdat = 8'hA5;
      prl_last = 1'b1;
    end
  end

  // line monitor: two samples per UI (first half at mid tick, second at boundary)
  initial forever begin
    @(negedge clk);
    if (ptx_ack === 1'b1) begin
      acks++;
      chk("ack_oe_txact_prevoe", 64'({ptx_oe, ptx_txact, prev_oe}), 64'(3'b001));
    end
    if (ptx_hui && ptx_oe === 1'b1) smp.push_back(ptx_line);
    prev_oe = ptx_oe;
  end

  function automatic logic [31:0] crc32_ref();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (pay[i])
      for (int b = 0; b < 8; b++)
        c = ((c[0] ^ pay[i][b]) != 1'b0) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction

  task automatic push_k(input logic [4:0] k);
    for (int b = 0; b < 5; b++) expq.push_back(k[b]);
  endtask

  task automatic build(input logic [6:0] a);
    logic [31:0] c;
    expq.delete();
    if (a[5]) for (int i = 0; i < 64; i++) expq.push_back(1'(i % 2));
    case (a[2:0])
      3'd1: begin push_k(S1); push_k(S1); push_k(S1); push_k(S2); end
      3'd2: begin push_k(S1); push_k(S1); push_k(S3); push_k(S3); end
      3'd3: begin push_k(S1); push_k(S3); push_k(S1); push_k(S3); end
      3'd4: begin push_k(S1); push_k(R2); push_k(R2); push_k(S3); end
      3'd5: begin push_k(S1); push_k(R2); push_k(S3); push_k(S2); end
      3'd6: begin push_k(R1); push_k(R1); push_k(R1); push_k(R2); end
      3'd7: begin push_k(R1); push_k(S1); push_k(R1); push_k(S3); end
      default: ;
    endcase
    if (a[2:0] < 3'd6) begin
      foreach (pay[i]) begin
        push_k(enc_t[pay[i][3:0]]);
        push_k(enc_t[pay[i][7:4]]);
      end
      if (a[4]) begin
        c = crc32_ref();
        for (int n = 0; n < 8; n++) push_k(enc_t[c[4*n +: 4]]);
      end
      if (a[3]) push_k(EOPK);
    end
  endtask

  task automatic start_frame(input logic [6:0] a, input int nb, input bit fixed, input string nm);
    if (!fixed) begin
      pay.delete();
      for (int i = 0; i < nb; i++) pay.push_back(8'($urandom_range(0, 255)));
    end
    idx = 0; pend = 0; pops = 0; acks = 0;
    smp.delete();
    build(a);
    @(negedge clk);
    prl_txauto = a;
    prl_txreq  = 1'b1;
    @(negedge clk);
    prl_txreq  = 1'b0;
    chk({nm, "_txact_next_cycle"}, 64'(ptx_txact), 64'(1));
  endtask

  task automatic run_frame(input logic [6:0] a, input int nb, input bit fixed,
                           input bit midreq, input int exp_ui, input string nm);
    int  limit, mism, nbits, unstable, exp_pops;
    bit  done, b;
    start_frame(a, nb, fixed, nm);
    exp_pops = (a[2:0] >= 3'd6) ? 0 : pay.size();
    limit = (expq.size() + 4) * 8 + 200;
    done  = 0;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge clk);
      prl_txreq = midreq && (c == 100);
      if (acks > 0) done = 1;
    end
    prl_txreq = 1'b0;
    chk({nm, "_ack_seen"}, 64'(done), 64'(1));
    repeat (12) @(negedge clk);
    chk({nm, "_acks"}, 64'(acks), 64'(1));
    chk({nm, "_pops"}, 64'(pops), 64'(exp_pops));
    chk({nm, "_txact_after"}, 64'({ptx_txact, ptx_oe}), 64'(0));
    chk({nm, "_oe_halfui"}, 64'(smp.size()), 64'(2 * (expq.size() + 1)));
    nbits = (smp.size() >= 2) ? (smp.size() / 2 - 1) : 0;
    if (exp_ui >= 0) chk({nm, "_ui_before_tail"}, 64'(nbits), 64'(exp_ui));
    mism = -1;
    unstable = 0;
    for (int i = 0; i < nbits && i < expq.size(); i++) begin
`ifdef UPTX_BMC_EN
      b = smp[2*i] ^ smp[2*i+1];
`else
      b = smp[2*i];
`endif
      if (b != expq[i] && mism < 0) mism = i;
    end
    chk({nm, "_bits_firstbad_plus1"}, 64'(mism + 1), 64'(0));
    if (smp.size() >= 2) chk({nm, "_tail_low"}, 64'(smp[smp.size()-1]), 64'(0));
`ifdef UPTX_BMC_EN
    if (a[5] && smp.size() >= 130) begin
      for (int i = 0; i < 128; i++) if (smp[i] != smp[i+1]) unstable++;
      chk({nm, "_bmc_prea_transitions"}, 64'(unstable), 64'(96));
    end
`else
    for (int i = 0; i + 1 < smp.size(); i += 2) if (smp[i] != smp[i+1]) unstable++;
    chk({nm, "_nrz_midbit_changes"}, 64'(unstable), 64'(0));
`endif
  endtask

  initial begin
    int ok;
    logic [6:0] ra;
    // reset: outputs forced low, request ignored
    arst = 1'b1;
    prl_txreq = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fifopop", 64'(ptx_fifopop), 64'(0));
    chk("rst_txact",   64'(ptx_txact),   64'(0));
    chk("rst_ack",     64'(ptx_ack),     64'(0));
    chk("rst_line",    64'(ptx_line),    64'(0));
    chk("rst_oe",      64'(ptx_oe),      64'(0));
    prl_txreq = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    repeat (4) @(negedge clk);

    // GoodCRC with a stray request mid-frame
    pay.delete(); pay.push_back(8'h41); pay.push_back(8'h00);
    run_frame(7'h39, 2, 1, 1, 149, "goodcrc");
    // Hard Reset: no payload, no CRC, no EOP
    run_frame(7'h2E, 3, 0, 0, 84, "hardrst");
    // 30-byte data frame, CRC off
    run_frame(7'h29, 30, 0, 0, 389, "data30");
    // single-byte payload with CRC, no EOP
    run_frame(7'h31, 1, 0, 0, 134, "onebyte");
    // no preamble, no ordered set
    run_frame(7'h08, 2, 0, 0, 25, "bare");
    for (int r = 0; r < 4; r++) begin
      ra = 7'($urandom_range(0, 127));
      run_frame(ra, $urandom_range(1, 4), 0, 0, -1, $sformatf("rand%0d", r));
    end

    // abort during DATA
    start_frame(7'h29, 30, 0, "abort");
    ok = 0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      @(negedge clk);
      if (pops >= 3) ok = 1;
    end
    chk("abort_reached_data", 64'(ok), 64'(1));
    repeat (3) @(negedge clk);
    arst = 1'b1;
    #1;
    chk("abort_oe",    64'(ptx_oe),    64'(0));
    chk("abort_txact", 64'(ptx_txact), 64'(0));
    chk("abort_line",  64'(ptx_line),  64'(0));
    repeat (20) @(negedge clk);
    arst = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_no_ack", 64'(acks), 64'(0));
    chk("abort_idle",   64'({ptx_oe, ptx_txact}), 64'(0));
    run_frame(7'h3A, 3, 0, 0, -1, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
